bram_responder: RTL and testbench

Memory-side responder for the 32-bit single-port block RAM. It accepts read and write requests from one initiator over a valid/ready request channel and returns a response over a valid/ready response channel. It converts byte-strobed partial writes into read-modify-write sequences and sequences the RAM's one-cycle registered read latency. It sits between any core-side state machine and the `SPBRAM` instance, which it drives exclusively.

---
 rtl/bram_responder.sv | 156 +++++++++++++++
 tb/tb_bram_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bram_responder.sv
// Request/response front end for a 32-bit single-port block RAM: sequences registered reads
// and turns byte-strobed writes into read-modify-write. Optional checking: BRAM_RESPONDER_CHECK_EN.
module bram_responder #(
  parameter int ADDRESS_BITWIDTH = 13,
  parameter int DATA_BITWIDTH    = 32
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [31:0]                 req_address,
  input  logic [3:0]                  req_wstrb,
  input  logic [DATA_BITWIDTH-1:0]    req_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_BITWIDTH-1:0]    rsp_rdata,
  output logic                        rsp_error,
  output logic                        mem_write_enable,
  output logic [ADDRESS_BITWIDTH-1:0] mem_address,
  output logic [DATA_BITWIDTH-1:0]    mem_data_in,
  input  logic [DATA_BITWIDTH-1:0]    mem_data_out
);

  localparam int NLANES = DATA_BITWIDTH / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_CAP,
    ST_WR,
    ST_ACK,
    ST_RESP
  } state_e;

  state_e                        state_q;
  logic                          req_ready_q;
  logic                          rsp_valid_q;
  logic [DATA_BITWIDTH-1:0]      rsp_rdata_q;
  logic                          rsp_error_q;
  logic                          mem_we_q;
  logic [ADDRESS_BITWIDTH-1:0]   mem_addr_q;
  logic [DATA_BITWIDTH-1:0]      mem_din_q;
  logic                          write_q;
  logic [3:0]                    wstrb_q;
  logic [DATA_BITWIDTH-1:0]      wdata_q;
  logic [DATA_BITWIDTH-1:0]      merged_d;
  logic [ADDRESS_BITWIDTH-1:0]   req_word;
  logic                          req_err;

  assign req_word = req_address[ADDRESS_BITWIDTH+1:2];

`ifdef BRAM_RESPONDER_CHECK_EN
  assign req_err = (req_address[1:0] != 2'b00) || (req_address[31:ADDRESS_BITWIDTH+2] != '0);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_address[31:ADDRESS_BITWIDTH+2], req_address[1:0]};
  assign req_err = 1'b0;
`endif

  // Strobed lanes come from the latched write data, the rest from the word just read.
  generate
    for (genvar gi = 0; gi < NLANES; gi++) begin : g_merge
      assign merged_d[8*gi +: 8] = wstrb_q[gi] ? wdata_q[8*gi +: 8] : mem_data_out[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      write_q     <= 1'b0;
      wstrb_q     <= '0;
      wdata_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            write_q     <= req_write;
            wstrb_q     <= req_wstrb;
            wdata_q     <= req_wdata;
            rsp_error_q <= 1'b0;
            // Non-RAM responses go through ACK so they share the full-write latency.
            if (req_err) begin
              rsp_error_q <= 1'b1;
              rsp_rdata_q <= '0;
              state_q     <= ST_ACK;
            end else if (req_write && (req_wstrb == 4'b0000)) begin
              rsp_rdata_q <= '0;
              state_q     <= ST_ACK;
            end else if (req_write && (req_wstrb == 4'b1111)) begin
              mem_addr_q <= req_word;
              mem_din_q  <= req_wdata;
              mem_we_q   <= 1'b1;
              state_q    <= ST_WR;
            end else begin
              mem_addr_q <= req_word;
              state_q    <= ST_RD;
            end
          end
        end
        ST_RD: begin
          state_q <= ST_RD_CAP;
        end
        ST_RD_CAP: begin
          if (write_q) begin
            mem_din_q <= merged_d;
            mem_we_q  <= 1'b1;
            state_q   <= ST_WR;
          end else begin
            rsp_rdata_q <= mem_data_out;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_WR: begin
          mem_we_q    <= 1'b0;
          rsp_rdata_q <= mem_din_q;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_ACK: begin
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready        = req_ready_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_rdata        = rsp_rdata_q;
  assign rsp_error        = rsp_error_q;
  assign mem_write_enable = mem_we_q;
  assign mem_address      = mem_addr_q;
  assign mem_data_in      = mem_din_q;

endmodule

// File: tb/tb_bram_responder.sv
// Self-checking bench for bram_responder: behavioural RAM on the memory port, word-array
// reference model, directed scenarios followed by randomized requests.
module tb_bram_responder;

  localparam int AW = 13;
  localparam int DEPTH = 1 << AW;
`ifdef BRAM_RESPONDER_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [31:0]   req_address;
  logic [3:0]    req_wstrb;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_error;
  logic          mem_write_enable;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_data_in;
  logic [31:0]   mem_data_out;

  logic [31:0] ram [DEPTH];
  logic [31:0] model_mem [DEPTH];

  int vectors = 0;
  int miscompares = 0;

  bram_responder #(.ADDRESS_BITWIDTH(AW), .DATA_BITWIDTH(32)) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_address(req_address),
    .req_wstrb(req_wstrb),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .mem_write_enable(mem_write_enable),
    .mem_address(mem_address),
    .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  always #5 sys_clk = ~sys_clk;

  // Single-port RAM with one-cycle registered read.
  always @(posedge sys_clk) begin
    if (mem_write_enable) ram[mem_address] <= mem_data_in;
    mem_data_out <= ram[mem_address];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // One request end to end; called at posedge+1 with the responder idle.
  task automatic run(input bit wr, input logic [31:0] addr, input logic [3:0] strb,
                     input logic [31:0] wd, input int stall);
    logic [AW-1:0] idx;
    bit            err;
    logic [31:0]   exp_rd;
    logic [31:0]   merged;
    int            exp_lat;
    int            exp_we;
    int            lat;
    int            we_cnt;
    logic [31:0]   we_addr;
    logic [31:0]   held;
    idx = addr[AW+1:2];
    err = CHECK && ((addr[1:0] != 2'b00) || (addr[31:AW+2] != '0));
    exp_we = 0;
    if (err) begin
      exp_rd = 32'h0; exp_lat = 1;
    end else if (!wr) begin
      exp_rd = model_mem[idx]; exp_lat = 2;
    end else if (strb == 4'b0000) begin
      exp_rd = 32'h0; exp_lat = 1;
    end else begin
      merged = model_mem[idx];
      for (int b = 0; b < 4; b++) if (strb[b]) merged[8*b +: 8] = wd[8*b +: 8];
      model_mem[idx] = merged;
      exp_rd = merged;
      exp_lat = (strb == 4'b1111) ? 1 : 3;
      exp_we = 1;
    end
    $display("req %s addr=%h strb=%b wdata=%h -> expect rdata=%h err=%0d lat=%0d",
             wr ? "WR" : "RD", addr, strb, wd, exp_rd, err, exp_lat);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_address = addr; req_wstrb = strb; req_wdata = wd;
    tick();
    req_valid = 1'b0; req_write = $urandom_range(0, 1); req_address = $urandom;
    req_wstrb = 4'($urandom); req_wdata = $urandom;
    lat = 0; we_cnt = 0; we_addr = '0;
    if (mem_write_enable) begin we_cnt++; we_addr = 32'(mem_address); end
    while (!rsp_valid && lat < 16) begin
      tick();
      lat++;
      if (mem_write_enable) begin we_cnt++; we_addr = 32'(mem_address); end
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("rsp_error", 32'(rsp_error), 32'(err));
    check("we_pulses", 32'(we_cnt), 32'(exp_we));
    if (exp_we == 1) check("we_address", we_addr, 32'(idx));
    check("req_ready_busy", 32'(req_ready), 32'd0);
    held = rsp_rdata;
    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_rdata", rsp_rdata, held);
      check("stall_ready", 32'(req_ready), 32'd0);
      check("stall_we", 32'(mem_write_enable), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    check("req_ready_back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  s;
    for (int i = 0; i < DEPTH; i++) begin ram[i] = 32'h0; model_mem[i] = 32'h0; end
    sys_rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_address = '0;
    req_wstrb = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) tick();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_error", 32'(rsp_error), 32'd0);
    check("rst_mem_we", 32'(mem_write_enable), 32'd0);
    check("rst_mem_addr", 32'(mem_address), 32'd0);
    check("rst_mem_din", mem_data_in, 32'd0);
    sys_rst_n = 1'b1;
    tick();
    check("post_rst_ready", 32'(req_ready), 32'd1);

    // Full write, read back, partial RMW, zero strobe, long stall.
    run(1'b1, 32'h10, 4'b1111, 32'hABCD_EF12, 0);
    run(1'b0, 32'h10, 4'b0000, 32'h0, 0);
    run(1'b1, 32'h10, 4'b0101, 32'h1122_3344, 1);
    run(1'b0, 32'h10, 4'b0000, 32'h0, 0);
    run(1'b1, 32'h10, 4'b0000, 32'hDEAD_BEEF, 0);
    run(1'b0, 32'h10, 4'b1111, 32'h0, 5);
`ifdef BRAM_RESPONDER_CHECK_EN
    run(1'b0, 32'h12, 4'b0000, 32'h0, 0);
    run(1'b1, 32'h0000_8000, 4'b1111, 32'h5555_AAAA, 0);
    run(1'b0, 32'h0, 4'b0000, 32'h0, 0);
`else
    run(1'b1, 32'h8010, 4'b1111, 32'h0BAD_F00D, 0);
    run(1'b0, 32'h10, 4'b0000, 32'h0, 0);
`endif

    // Reset during RD_CAP of a partial write.
    req_valid = 1'b1; req_write = 1'b1; req_address = 32'h10; req_wstrb = 4'b0011;
    req_wdata = 32'hCAFE_0000;
    tick();
    req_valid = 1'b0;
    tick();
    sys_rst_n = 1'b0;
    #1;
    check("abort_we", 32'(mem_write_enable), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("abort_we_hold", 32'(mem_write_enable), 32'd0);
      check("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end
    sys_rst_n = 1'b1;
    tick();
    check("abort_ready_back", 32'(req_ready), 32'd1);
    check("abort_no_rsp2", 32'(rsp_valid), 32'd0);
    run(1'b0, 32'h10, 4'b0000, 32'h0, 0);

    // Randomized traffic over a small window, with occasional out-of-range and misaligned addresses.
    for (int n = 0; n < 60; n++) begin
      a = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 3) == 0) a = a | (32'($urandom_range(1, 255)) << 15);
      if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
      s = 4'($urandom);
      if ($urandom_range(0, 3) == 0) s = 4'b1111;
      run(1'($urandom_range(0, 1)), a, s, $urandom, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
